aes192_round_sequencer: RTL and testbench

AES192_ROUND_SEQUENCER -- requirements
Module: aes192_round_sequencer

---
 rtl/aes192_round_sequencer_if.sv | 38 +++
 rtl/aes192_round_sequencer.sv | 120 ++++++++++++
 tb/tb_aes192_round_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes192_round_sequencer_if.sv
// Bundles the block handshake, round-key mux and round-datapath signals of the
// AES-192 round sequencer.
interface aes192_round_sequencer_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  rk_sel;
    logic [DATA_W-1:0] rk_data;
    logic              rnd_start;
    logic [DATA_W-1:0] rnd_in;
    logic [DATA_W-1:0] rnd_key;
    logic              rnd_final;
    logic              rnd_done;
    logic [DATA_W-1:0] rnd_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [15:0]       blk_cnt;
    logic              proto_err;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, rk_data, rnd_done, rnd_out, out_ready,
        output in_ready, rk_sel, rnd_start, rnd_in, rnd_key, rnd_final,
               out_valid, out_data, busy, blk_cnt, proto_err
    );

    // Environment side: block source/sink, key mux and round datapath
    modport master (
        output in_valid, in_data, rk_data, rnd_done, rnd_out, out_ready,
        input  in_ready, rk_sel, rnd_start, rnd_in, rnd_key, rnd_final,
               out_valid, out_data, busy, blk_cnt, proto_err
    );
endinterface

// File: rtl/aes192_round_sequencer.sv
// Sequences one AES-192 block through an external single-round datapath:
// initial key add, ROUNDS round launches, then ciphertext hand-off.
module aes192_round_sequencer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ROUNDS = 12,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    aes192_round_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(ROUNDS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

    state_e            fsm_q, fsm_d;
    logic [IDX_W-1:0]  r_q, r_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic              perr_q, perr_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              rnd_start_q, rnd_start_d;
    logic              rnd_final_q, rnd_final_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  rk_sel_q, rk_sel_d;

    // Next state, datapath capture and registered-output precompute
    always_comb begin
        fsm_d     = fsm_q;
        r_d       = r_q;
        st_d      = st_q;
        blk_cnt_d = blk_cnt_q;
        perr_d    = perr_q;

        unique case (fsm_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    st_d  = bus.in_data ^ bus.rk_data;
                    r_d   = IDX_W'(1);
                    fsm_d = ISSUE;
                end
            end
            ISSUE: fsm_d = WAIT;
            WAIT: begin
                if (bus.rnd_done) begin
                    st_d = bus.rnd_out;
                    if (r_q == LAST_RND) begin
                        fsm_d = OUT;
                    end else begin
                        r_d   = r_q + IDX_W'(1);
                        fsm_d = ISSUE;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    r_d       = '0;
                    fsm_d     = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        // A completion outside WAIT (including the launch cycle) is a protocol error
        if (bus.rnd_done && (fsm_q != WAIT)) begin
            perr_d = 1'b1;
        end

        in_ready_d  = (fsm_d == IDLE);
        busy_d      = (fsm_d != IDLE);
        rnd_start_d = (fsm_d == ISSUE);
        rnd_final_d = ((fsm_d == ISSUE) || (fsm_d == WAIT)) && (r_d == LAST_RND);
        out_valid_d = (fsm_d == OUT);
        rk_sel_d    = (fsm_d == IDLE) ? '0 : r_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fsm_q       <= IDLE;
            r_q         <= '0;
            st_q        <= '0;
            blk_cnt_q   <= '0;
            perr_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            rnd_start_q <= 1'b0;
            rnd_final_q <= 1'b0;
            out_valid_q <= 1'b0;
            rk_sel_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            r_q         <= r_d;
            st_q        <= st_d;
            blk_cnt_q   <= blk_cnt_d;
            perr_q      <= perr_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            rnd_start_q <= rnd_start_d;
            rnd_final_q <= rnd_final_d;
            out_valid_q <= out_valid_d;
            rk_sel_q    <= rk_sel_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rk_sel    = rk_sel_q;
    assign bus.rnd_start = rnd_start_q;
    assign bus.rnd_in    = st_q;
    assign bus.rnd_key   = bus.rk_data;
    assign bus.rnd_final = rnd_final_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = st_q;
    assign bus.blk_cnt   = blk_cnt_q;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_aes192_round_sequencer.sv
// Bench for aes192_round_sequencer: AES-192 reference round datapath and key mux
// around the sequencer, with a ciphertext scoreboard.
module tb_aes192_round_sequencer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ROUNDS = 12;
    localparam int unsigned IDX_W  = 4;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    aes192_round_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    aes192_round_sequencer #(.DATA_W(DATA_W), .ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk     [0:15];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] sb_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] x, input logic [127:0] k,
                                               input logic fin);
        logic [127:0] y;
        y = sub_shift(x);
        if (!fin) y = mix(y);
        return y ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= int'(ROUNDS); r++) s = aes_round(s, rk[r], r == int'(ROUNDS));
        return s;
    endfunction

    task automatic build_tables(input logic [191:0] key);
        logic [31:0] w [0:51];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 256; i++) sbox_t[i] = sb_calc(8'(i));
        for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int k = 0; k < 16; k++)
            rk[k] = (k <= 12) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
    endtask

    assign bus.rk_data = rk[bus.rk_sel];

    // ---------------- round datapath model ----------------
    int           mcnt     = 0;
    logic [127:0] mres     = '0;
    bit           rand_lat = 1'b0;
    int           fix_lat  = 1;
    logic         spur     = 1'b0;

    always @(posedge ap_clk) begin
        if (bus.rnd_start) begin
            mcnt <= rand_lat ? int'($urandom_range(8, 1)) : fix_lat;
            mres <= aes_round(bus.rnd_in, bus.rnd_key, bus.rnd_final);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign bus.rnd_done = (mcnt == 1) | spur;
    assign bus.rnd_out  = mres;

    // ---------------- monitors / scoreboard ----------------
    logic [127:0] sb [$];
    int           exp_idx = 0;
    logic [15:0]  exp_blk = 16'h0;

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                check("idle_rk_sel", 128'(bus.rk_sel), 128'(0));
                sb.push_back(aes_enc(bus.in_data));
                exp_idx = 1;
            end
            if (bus.rnd_start) begin
                check("rk_sel", 128'(bus.rk_sel), 128'(exp_idx));
                check("rnd_final", 128'(bus.rnd_final), 128'(exp_idx == int'(ROUNDS)));
                exp_idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_rnd_final", 128'(bus.rnd_final), 128'(0));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_empty: observed out_data %h with no block expected", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, sb.pop_front());
                    exp_blk = exp_blk + 16'd1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_in(input logic [127:0] pt);
        int n;
        n = 0;
        while (!bus.in_ready && n < 3000) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check("in_ready_wait", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] pt);
        int n;
        drive_in(pt);
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check("block_done_wait", 128'(sb.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  128'(bus.in_ready),  128'(0));
        check({tag, "_busy"},      128'(bus.busy),      128'(0));
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_rnd_start"}, 128'(bus.rnd_start), 128'(0));
        check({tag, "_rnd_final"}, 128'(bus.rnd_final), 128'(0));
        check({tag, "_rk_sel"},    128'(bus.rk_sel),    128'(0));
        check({tag, "_blk_cnt"},   128'(bus.blk_cnt),   128'(0));
        check({tag, "_proto_err"}, 128'(bus.proto_err), 128'(0));
        check({tag, "_out_data"},  bus.out_data,        128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        build_tables(192'h000102030405060708090a0b0c0d0e0f1011121314151617);

        // Reset values, then first in_ready one cycle after release
        repeat (3) @(negedge ap_clk);
        check_reset_outputs("rst");
        ap_rst_n = 1'b1;
        #1;
        check("in_ready_at_release", 128'(bus.in_ready), 128'(0));
        @(negedge ap_clk);
        check("in_ready_first_cycle", 128'(bus.in_ready), 128'(1));

        // FIPS-197 AES-192 vector with 1-cycle round latency
        pt = 128'h00112233445566778899aabbccddeeff;
        check("model_fips", aes_enc(pt), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        @(negedge ap_clk);
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check("fips_latency", 128'(n), 128'(2 * ROUNDS + 1));
        check("fips_out_data", bus.out_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check("fips_in_ready_busy", 128'(bus.in_ready), 128'(0));
        @(posedge ap_clk); #1;
        check("fips_blk_cnt", 128'(bus.blk_cnt), 128'(1));
        check("fips_proto_err", 128'(bus.proto_err), 128'(0));

        // Output back-pressure for 10 cycles
        bus.out_ready = 1'b0;
        drive_in({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("stall_out_valid", 128'(bus.out_valid), 128'(1));
            check("stall_out_data", bus.out_data, (sb.size() != 0) ? sb[0] : 128'hx);
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
            check("stall_blk_cnt", 128'(bus.blk_cnt), 128'(exp_blk));
        end
        @(posedge ap_clk); #1;
        bus.out_ready = 1'b1;
        @(posedge ap_clk); #1;
        check("stall_release_blk_cnt", 128'(bus.blk_cnt), 128'(2));
        check("stall_release_sb", 128'(sb.size()), 128'(0));

        // Spurious rnd_done while idle
        spur = 1'b1;
        @(posedge ap_clk); #1;
        spur = 1'b0;
        check("spur_proto_err", 128'(bus.proto_err), 128'(1));
        run_block({$urandom, $urandom, $urandom, $urandom});
        check("spur_proto_err_sticky", 128'(bus.proto_err), 128'(1));

        // Random round latency 1..8 over 100 blocks
        rand_lat = 1'b1;
        for (int b = 0; b < 100; b++) run_block({$urandom, $urandom, $urandom, $urandom});
        rand_lat = 1'b0;
        check("random_blk_cnt", 128'(bus.blk_cnt), 128'(103));

        // Reset pulse while waiting on round 6
        fix_lat = 8;
        drive_in({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!(bus.rnd_start && bus.rk_sel == IDX_W'(6)) && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        check("reach_round6", 128'(bus.rk_sel), 128'(6));
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        exp_blk = 16'h0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (12) @(negedge ap_clk);
        check("late_done_proto_err", 128'(bus.proto_err), 128'(1));
        check("abandoned_no_out", 128'(bus.blk_cnt), 128'(0));
        fix_lat = 1;
        run_block({$urandom, $urandom, $urandom, $urandom});
        check("after_rst_blk_cnt", 128'(bus.blk_cnt), 128'(1));

        // Block counter wrap
        @(negedge ap_clk);
        force dut.blk_cnt_q = 16'hffff;
        @(negedge ap_clk);
        release dut.blk_cnt_q;
        check("preload_blk_cnt", 128'(bus.blk_cnt), 128'(16'hffff));
        exp_blk = 16'hffff;
        run_block({$urandom, $urandom, $urandom, $urandom});
        check("wrap_blk_cnt", 128'(bus.blk_cnt), 128'(16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
